// File: rtl/alu_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_divider
// Description : Multi-cycle restoring shift-subtract divider. Divides a
//               product-width dividend by a narrow divisor, one quotient bit
//               per clock, under a start/busy/done handshake.
//               Optional macro ALU_DIV_SIGNED_EN adds two's-complement mode
//               selected by is_signed.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_divider #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4,
    parameter int CNT_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    input  logic                  is_signed,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quot,
    output logic [DIVISOR_W-1:0]  rem,
    output logic                  div_by_zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter value present on the edge that performs the final step
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(DIVIDEND_W - 1);

    state_t                r_state;
    state_t                w_state_nxt;

    logic [DIVISOR_W:0]    r_p;       // partial remainder, one guard bit
    logic [DIVIDEND_W-1:0] r_q;       // dividend shifting out, quotient shifting in
    logic [DIVISOR_W-1:0]  r_div;     // latched divisor magnitude
    logic [CNT_W-1:0]      r_cnt;
    logic [DIVIDEND_W-1:0] r_quot;
    logic [DIVISOR_W-1:0]  r_rem;
    logic                  r_dbz;

    logic                  w_div_zero;
    logic                  w_last;
    logic [DIVISOR_W:0]    w_p_sh;
    logic                  w_fits;
    logic [DIVISOR_W:0]    w_p_nxt;
    logic [DIVIDEND_W-1:0] w_q_nxt;
    logic [DIVIDEND_W-1:0] w_dvd_mag;
    logic [DIVISOR_W-1:0]  w_dvs_mag;
    logic [DIVISOR_W-1:0]  w_rem_raw;
    logic [DIVIDEND_W-1:0] w_quot_res;
    logic [DIVISOR_W-1:0]  w_rem_res;
    logic [2:0]            w_unused_bits;

    assign w_div_zero = (divisor == '0);
    assign w_last     = (r_cnt == c_last_cnt);

    // One restoring step: shift {P,Q} left, trial-subtract the divisor from P.
    // P stays below the divisor after every step, so the shifted value always
    // fits in DIVISOR_W+1 bits and the guard bit of r_p is never set.
    assign w_p_sh  = {r_p[DIVISOR_W-1:0], r_q[DIVIDEND_W-1]};
    assign w_fits  = (w_p_sh >= {1'b0, r_div});
    assign w_p_nxt = w_fits ? (w_p_sh - {1'b0, r_div}) : w_p_sh;
    assign w_q_nxt = {r_q[DIVIDEND_W-2:0], w_fits};
    assign w_rem_raw = w_p_nxt[DIVISOR_W-1:0];

`ifdef ALU_DIV_SIGNED_EN
    logic w_dvd_neg;
    logic w_dvs_neg;
    logic r_neg_q;
    logic r_neg_r;

    // The iteration is always unsigned; signed mode feeds it magnitudes and
    // fixes the signs afterwards. The most negative dividend's magnitude still
    // fits as an unsigned value, so -128/-1 wraps to 0x80 naturally.
    assign w_dvd_neg  = is_signed & dividend[DIVIDEND_W-1];
    assign w_dvs_neg  = is_signed & divisor[DIVISOR_W-1];
    assign w_dvd_mag  = w_dvd_neg ? -dividend : dividend;
    assign w_dvs_mag  = w_dvs_neg ? -divisor : divisor;
    assign w_quot_res = r_neg_q ? -w_q_nxt : w_q_nxt;
    assign w_rem_res  = r_neg_r ? -w_rem_raw : w_rem_raw;

    // Capture result-sign fixups at accept time alongside the operands
    always_ff @(posedge clk) begin
        if (rst) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (r_state == ST_IDLE && start && !w_div_zero) begin
            r_neg_q <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r <= w_dvd_neg;
        end
    end
`else
    assign w_dvd_mag  = dividend;
    assign w_dvs_mag  = divisor;
    assign w_quot_res = w_q_nxt;
    assign w_rem_res  = w_rem_raw;
`endif

    // Guard bits are structurally zero; is_signed is inert in the unsigned build
    assign w_unused_bits = {is_signed, r_p[DIVISOR_W], w_p_nxt[DIVISOR_W]};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = w_div_zero ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operand latch, iteration datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p    <= '0;
            r_q    <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_dbz  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_div_zero) begin
                            r_quot <= '1;
                            r_rem  <= dividend[DIVISOR_W-1:0];
                            r_dbz  <= 1'b1;
                        end else begin
                            r_p   <= '0;
                            r_q   <= w_dvd_mag;
                            r_div <= w_dvs_mag;
                            r_cnt <= '0;
                            r_dbz <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    r_p   <= w_p_nxt;
                    r_q   <= w_q_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_quot <= w_quot_res;
                        r_rem  <= w_rem_res;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign quot        = r_quot;
    assign rem         = r_rem;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq_divider
// Description : Self-checking bench for alu_seq_divider. A cycle-level model
//               computes results with plain '/' and '%' and a countdown to
//               completion; directed vectors add literal expectations.
//               Signed vectors run only when ALU_DIV_SIGNED_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq_divider;

`ifdef ALU_DIV_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       is_signed;
    logic       busy;
    logic       done;
    logic [7:0] quot;
    logic [3:0] rem;
    logic       div_by_zero;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_seq_divider #(
        .DIVIDEND_W (8),
        .DIVISOR_W  (4),
        .CNT_W      (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .is_signed   (is_signed),
        .busy        (busy),
        .done        (done),
        .quot        (quot),
        .rem         (rem),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic reference: quotient truncates toward zero, remainder takes
    // the dividend's sign, results wrap to the port widths.
    function automatic void model_div(input logic [7:0] a, input logic [3:0] b, input logic sgn,
                                      output logic [7:0] q, output logic [3:0] r);
        int ia;
        int ib;
        int iq;
        int ir;
        ia = int'(a);
        ib = int'(b);
        if (sgn && SIGNED_BUILD) begin
            ia = int'($signed(a));
            ib = int'($signed(b));
        end
        iq = ia / ib;
        ir = ia % ib;
        q  = iq[7:0];
        r  = ir[3:0];
    endfunction

    // Model: an accepted division publishes its result 8 edges later (zero
    // divisor: on the accept edge), done lasts one cycle, then idle again.
    int         m_cnt  = 0;
    bit         m_done = 1'b0;
    bit         m_en   = 1'b0;
    bit         m_dbz  = 1'b0;
    logic [7:0] m_quot = '0;
    logic [3:0] m_rem  = '0;
    logic [7:0] m_pq;
    logic [3:0] m_pr;

    always @(posedge clk) begin
        if (rst) begin
            m_en   = 1'b1;
            m_cnt  = 0;
            m_done = 1'b0;
            m_quot = '0;
            m_rem  = '0;
            m_dbz  = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_quot = m_pq;
                m_rem  = m_pr;
                m_done = 1'b1;
            end
        end else if (start) begin
            if (divisor == 4'd0) begin
                m_quot = 8'hFF;
                m_rem  = dividend[3:0];
                m_dbz  = 1'b1;
                m_done = 1'b1;
            end else begin
                model_div(dividend, divisor, is_signed, m_pq, m_pr);
                m_dbz = 1'b0;
                m_cnt = 8;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (m_en) begin
            check("cyc_busy", {31'd0, busy}, {31'd0, (m_cnt > 0)});
            check("cyc_done", {31'd0, done}, {31'd0, m_done});
            check("cyc_quot", {24'd0, quot}, {24'd0, m_quot});
            check("cyc_rem",  {28'd0, rem},  {28'd0, m_rem});
            check("cyc_dbz",  {31'd0, div_by_zero}, {31'd0, m_dbz});
        end
    end

    // Issue one division; optionally poke a stray start at RUN cycle 'poke'.
    // Latency counts rising edges from the accept edge to the edge that
    // samples done high.
    task automatic run_div(input logic [7:0] a, input logic [3:0] b, input logic sgn,
                           input logic [7:0] eq, input logic [3:0] er, input logic ed,
                           input int elat, input int ebusy, input int poke, input string name);
        int n;
        int nb;
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        is_signed = sgn;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
        dividend  = 8'($urandom);
        divisor   = 4'($urandom);
        n  = 1;
        nb = 0;
        forever begin
            if (busy) nb++;
            if (done || n >= 30) break;
            if (n == poke) begin
                start    = 1'b1;
                dividend = 8'd9;
                divisor  = 4'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({name, "_latency"}, n, elat);
        check({name, "_busy_cycles"}, nb, ebusy);
        check({name, "_quot"}, {24'd0, quot}, {24'd0, eq});
        check({name, "_rem"}, {28'd0, rem}, {28'd0, er});
        check({name, "_dbz"}, {31'd0, div_by_zero}, {31'd0, ed});
        @(negedge clk);
        check({name, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int dq[$];
        int n;
        int nd;
        rst       = 1'b1;
        start     = 1'b0;
        dividend  = '0;
        divisor   = '0;
        is_signed = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_quot", {24'd0, quot}, 32'd0);
        check("rst_rem",  {28'd0, rem},  32'd0);
        check("rst_dbz",  {31'd0, div_by_zero}, 32'd0);
        rst = 1'b0;

        run_div(8'hC8, 4'd7,  1'b0, 8'h1C, 4'd4,  1'b0, 9, 8, -1, "u200_7");
        run_div(8'hFF, 4'd1,  1'b0, 8'hFF, 4'd0,  1'b0, 9, 8, -1, "u255_1");
        run_div(8'd13, 4'd15, 1'b0, 8'h00, 4'd13, 1'b0, 9, 8, -1, "u13_15");
        run_div(8'h55, 4'd0,  1'b0, 8'hFF, 4'h5,  1'b1, 1, 0, -1, "dbz");
        run_div(8'hC8, 4'd7,  1'b0, 8'h1C, 4'd4,  1'b0, 9, 8, 3,  "ignore_start");

        // Back-to-back: start held high, one result every 10 cycles
        @(negedge clk);
        dividend = 8'd100;
        divisor  = 4'd9;
        start    = 1'b1;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (done) dq.push_back(i);
        end
        start = 1'b0;
        check("b2b_count_ge4", {31'd0, (dq.size() >= 4)}, 32'd1);
        for (int i = 1; i < dq.size(); i++) begin
            check("b2b_period", dq[i] - dq[i-1], 10);
        end
        check("b2b_quot", {24'd0, quot}, 32'd11);
        check("b2b_rem",  {28'd0, rem},  32'd1);
        n = 0;
        while ((busy || done) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b2b_drain", {31'd0, (n < 20)}, 32'd1);

        // Reset during RUN aborts without a done pulse
        @(negedge clk);
        dividend = 8'hC8;
        divisor  = 4'd7;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_quot", {24'd0, quot}, 32'd0);
        check("abort_rem",  {28'd0, rem},  32'd0);
        check("abort_dbz",  {31'd0, div_by_zero}, 32'd0);
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("abort_no_done", nd, 0);
        run_div(8'd100, 4'd10, 1'b0, 8'd10, 4'd0, 1'b0, 9, 8, -1, "u100_10");

`ifdef ALU_DIV_SIGNED_EN
        run_div(8'h9C, 4'h7, 1'b1, 8'hF2, 4'hE, 1'b0, 9, 8, -1, "s_m100_7");
        run_div(8'h64, 4'h9, 1'b1, 8'hF2, 4'h2, 1'b0, 9, 8, -1, "s_100_m7");
        run_div(8'h80, 4'hF, 1'b1, 8'h80, 4'h0, 1'b0, 9, 8, -1, "s_m128_m1");
        run_div(8'h9C, 4'h7, 1'b0, 8'd22,  4'd2, 1'b0, 9, 8, -1, "s_off_156_7");
`endif

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire

// File: doc/alu_seq_divider.md
Name: alu_seq_divider

Overview:
- Multi-cycle restoring shift-subtract divider: the inverse of the ALU's combinational 4x4 multiply.
- Divides an 8-bit, product-width dividend by a 4-bit divisor.
- Returns an 8-bit quotient and a 4-bit remainder under a start/busy/done handshake.
- Sits beside the arithmetic unit and replaces its single-cycle divide on timing-critical paths.

Parameters:
- DIVIDEND_W, 8, dividend and quotient width.
- DIVISOR_W, 4, divisor and remainder width.
- CNT_W, 4, iteration counter width; must satisfy 2^CNT_W > DIVIDEND_W.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  DIVIDEND_W  dividend (Prod-width operand).
- divisor  input  DIVISOR_W  divisor.
- is_signed  input  1  signed-mode select; used only when ALU_DIV_SIGNED_EN is defined.
- busy  output  1  high in RUN.
- done  output  1  one-cycle completion pulse.
- quot  output  DIVIDEND_W  quotient, registered.
- rem  output  DIVISOR_W  remainder, registered.
- div_by_zero  output  1  set with done when divisor==0.

Behaviour:
- Reset:
  - state=IDLE; busy=0, done=0, quot=0, rem=0, div_by_zero=0; counter and working registers cleared.
  - Reset asserted mid-operation aborts the division; no done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE, start=1, divisor!=0:
  - Latch operands; partial remainder P (DIVISOR_W+1 bits) = 0; Q = dividend; counter = 0; go to RUN.
- IDLE, start=1, divisor==0:
  - Go to DONE directly.
  - quot = all ones; rem = dividend[DIVISOR_W-1:0]; div_by_zero = 1.
  - done pulses on the edge after the accept.
- RUN, each edge performs one restoring step:
  - {P,Q} shifted left by 1.
  - If P >= divisor: P = P - divisor, Q[0] = 1; else Q[0] = 0.
  - counter increments.
- After step DIVIDEND_W (counter == DIVIDEND_W-1 at the edge):
  - Load quot=Q and rem=P[DIVISOR_W-1:0] (width-truncated; always < divisor); go to DONE.
- Latency: done is high exactly DIVIDEND_W+1 rising edges after the edge that sampled start (9 for defaults). busy is high for exactly DIVIDEND_W cycles.
- DONE:
  - done=1 for one cycle, then go to IDLE.
  - quot, rem and div_by_zero hold until the next accepted start.
  - div_by_zero clears on the next accept.
- start while in RUN or DONE is ignored; it is neither queued nor restarted.
- start=1 held continuously: a new division is accepted on the first IDLE cycle after DONE, giving back-to-back throughput of one result per DIVIDEND_W+2 cycles.
- Operands may change freely after the accept edge; the latched copies are used.
- Unsigned result equals dividend/divisor and dividend%divisor for all non-zero divisors.

Optional Feature:
- Macro: ALU_DIV_SIGNED_EN.
- Defined, is_signed=1 at accept:
  - Operands are treated as two's complement; the unit latches their magnitudes plus sign bits.
  - Runs the same unsigned iteration.
  - On the final edge: negate quot if the signs differ; negate rem if the dividend is negative.
  - Truncation is toward zero.
  - Latency is unchanged.
  - -128 / -1 yields quot=0x80, rem=0 (wrap, no flag).
  - Divide-by-zero behaves as in unsigned mode.
- Defined, is_signed=0: behaviour is identical to the unsigned path.
- Undefined: is_signed is ignored and no sign logic is synthesised.

Test Plan:
- Reset, then dividend=0xC8 (200), divisor=7, start pulse -> busy for 8 cycles; done on edge 9; quot=28 (0x1C), rem=4, div_by_zero=0.
- dividend=0xFF, divisor=1 -> quot=0xFF, rem=0. Then dividend=13, divisor=15 -> quot=0, rem=13.
- dividend=0x55, divisor=0 -> done one edge after accept; quot=0xFF, rem=0x5, div_by_zero=1, busy never high.
- Start 200/7, then pulse start with 9/3 at cycle 3 of RUN -> second request ignored; result 28 r4. Then hold start=1 continuously -> back-to-back results every 10 cycles.
- Start 200/7, assert rst at RUN cycle 4 -> next edge: IDLE, all outputs 0, no done pulse. A new 100/10 then gives quot=10, rem=0.
- With ALU_DIV_SIGNED_EN, is_signed=1:
  - -100/7 (0x9C, 0x7) -> quot=-14 (0xF2), rem=-2 (0xE).
  - 100/-7 -> quot=0xF2, rem=2.
  - -128/-1 -> quot=0x80, rem=0.
